// File: rtl/usb_reg_arbiter_pkg.sv
// usb_reg_arbiter_pkg: shared FSM encoding and guard default for the register bus arbiter
package usb_reg_arbiter_pkg;
    typedef enum logic [2:0] {
        ST_USB,
        ST_SETUP,
        ST_ACCESS,
        ST_CAPTURE,
        ST_DONE
    } state_t;
    localparam int DEFAULT_GUARD = 4;
endpackage

// File: rtl/usb_reg_arbiter.sv
// usb_reg_arbiter: shares the USB register bus with one internal master, USB always wins
module usb_reg_arbiter
    import usb_reg_arbiter_pkg::*;
#(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pGUARD = DEFAULT_GUARD
) (
    input  logic                     clk_usb,
    input  logic                     reset,
    input  logic                     usb_active,
    input  logic [7:0]               usb_address,
    input  logic [pBYTECNT_SIZE-1:0] usb_bytecnt,
    input  logic [7:0]               usb_datao,
    input  logic                     usb_read,
    input  logic                     usb_write,
    output logic [7:0]               usb_datai,
    input  logic                     int_req,
    input  logic                     int_we,
    input  logic [7:0]               int_address,
    input  logic [pBYTECNT_SIZE-1:0] int_bytecnt,
    input  logic [7:0]               int_wdata,
    output logic                     int_gnt,
    output logic                     int_done,
    output logic [7:0]               int_rdata,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datao,
    output logic                     reg_read,
    output logic                     reg_write,
    input  logic [7:0]               reg_datai,
    output logic [7:0]               abort_count
);
    state_t                   state;
    logic [3:0]               guard;
    logic                     lat_we;
    logic [7:0]               lat_address;
    logic [7:0]               lat_wdata;
    logic [pBYTECNT_SIZE-1:0] lat_bytecnt;
    logic                     own_int;

    // DONE already hands the bus back to USB, so only the three middle states own it
    assign own_int     = state inside {ST_SETUP, ST_ACCESS, ST_CAPTURE};
    assign int_gnt     = state == ST_USB && !usb_active && int_req && guard == 4'(pGUARD);
    assign int_done    = state == ST_DONE;
    assign usb_datai   = reg_datai;
    assign reg_address = own_int ? lat_address : usb_address;
    assign reg_bytecnt = own_int ? lat_bytecnt : usb_bytecnt;
    assign reg_datao   = own_int ? lat_wdata : usb_datao;
    assign reg_write   = own_int ? state == ST_ACCESS && lat_we : usb_write;
    assign reg_read    = own_int ? state == ST_ACCESS && !lat_we : usb_read;

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            state       <= ST_USB;
            guard       <= '0;
            lat_we      <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
            lat_bytecnt <= '0;
            int_rdata   <= '0;
            abort_count <= '0;
        end else begin
            case (state)
                ST_USB: begin
                    if (int_gnt) begin
                        state       <= ST_SETUP;
                        guard       <= '0;
                        lat_we      <= int_we;
                        lat_address <= int_address;
                        lat_wdata   <= int_wdata;
                        lat_bytecnt <= int_bytecnt;
                    end else if (usb_active) begin
                        guard <= '0;
                    end else if (guard != 4'(pGUARD)) begin
                        guard <= guard + 4'd1;
                    end
                end
                ST_SETUP: begin
                    // last chance to back off before a strobe reaches the register blocks
                    if (usb_active) begin
                        state <= ST_USB;
                        if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
                    end else begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: state <= lat_we ? ST_DONE : ST_CAPTURE;
                ST_CAPTURE: begin
                    int_rdata <= reg_datai;
                    state     <= ST_DONE;
                end
                default: begin
                    guard <= '0;
                    state <= ST_USB;
                end
            endcase
        end
    end
endmodule
